// File: rtl/simple_circuit_stim_check_if.sv
// Stimulus/response bus between the sweep checker and the Simple_Circuit models.
// The master drives {A,B,C}; the slave side returns D/E from both models.
interface simple_circuit_stim_check_if;
    logic [2:0] abc;
    logic       d1;
    logic       e1;
    logic       d2;
    logic       e2;

    modport master (
        output abc,
        input  d1,
        input  e1,
        input  d2,
        input  e2
    );

    modport slave (
        input  abc,
        output d1,
        output e1,
        output d2,
        output e2
    );
endinterface

// File: rtl/simple_circuit_stim_check.sv
// Sweeps all 8 {A,B,C} vectors, waits a settle window, then checks both
// Simple_Circuit models against D = (A & B) | ~C, E = ~C.
module simple_circuit_stim_check #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    simple_circuit_stim_check_if.master     bus,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [CNT_W-1:0]                err_cnt,
    output logic [2:0]                      first_err_vec,
    output logic                            first_err_valid
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    state_t           state_q;
    logic [2:0]       abc_q;
    logic [7:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [2:0]       fvec_q;
    logic             fval_q;

    logic [1:0]       golden;
    logic             fail;
    logic [CNT_W-1:0] err_d;

    // A vector failing on both models still counts as one error.
    always_comb begin
        golden = {(abc_q[2] & abc_q[1]) | ~abc_q[0], ~abc_q[0]};
        fail   = ({bus.d1, bus.e1} != golden) ||
                 ({bus.d2, bus.e2} != golden);
        err_d  = err_q;
        if (fail && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            abc_q   <= 3'b000;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvec_q  <= 3'b000;
            fval_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= APPLY;
                        abc_q   <= 3'b000;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fvec_q  <= 3'b000;
                        fval_q  <= 1'b0;
                    end
                end
                APPLY: begin
                    cnt_q   <= SETTLE_LD;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 8'd1) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    if (fail && !fval_q) begin
                        fvec_q <= abc_q;
                        fval_q <= 1'b1;
                    end
                    if (abc_q == 3'd7) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        abc_q   <= abc_q + 3'd1;
                        state_q <= APPLY;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.abc         = abc_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fvec_q;
    assign first_err_valid = fval_q;

endmodule
